booth_seq_multiplier: RTL and testbench

- Multi-cycle, parametrised Booth multiplier: one radix-2^RADIX_LOG2 Booth digit per clock, accumulated into a running product.
- Successor to the combinational booth_encoder. Adds selectable radix (4 or 8), per-operation signed/unsigned mode, a valid/ready handshake on both sides, and output hold under back-pressure.
- Sits between operand staging and the result bus of the multiplier datapath.

---
 rtl/booth_seq_multiplier.sv | 142 ++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Sequential Booth multiplier: one radix-4 or radix-8 digit per clock,
// valid/ready on both sides, product held under back-pressure.
module booth_seq_multiplier #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned RADIX_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     multiplicand,
  input  logic [DATA_WIDTH-1:0]     multiplier,
  input  logic                      is_signed,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      busy
);

  localparam int unsigned W         = DATA_WIDTH;
  localparam int unsigned R         = RADIX_LOG2;
  localparam int unsigned NUM_TERMS = (W + R) / R;        // ceil((W+1)/R)
  localparam int unsigned PAD_W     = NUM_TERMS * R - W;
  localparam int unsigned BW        = NUM_TERMS * R + 1;  // padded B plus implicit 0
  localparam int unsigned PP_W      = W + 4;
  localparam int unsigned ACC_W     = 2 * W + R + 2;
  localparam int unsigned PW        = 2 * W;
  localparam int unsigned CNT_W     = $clog2(NUM_TERMS + 1);

  if (!(R == 2 || R == 3)) begin : g_bad_radix
    $error("booth_seq_multiplier: RADIX_LOG2 must be 2 or 3");
  end

  typedef enum logic [1:0] {IDLE, PRECOMP, ITER, DONE} state_t;

  state_t             state, state_next;
  logic [W:0]         a_reg;
  logic [W+2:0]       a3_reg;
  logic [BW-1:0]      b_sr;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic               accept_c;
  logic               last_c;
  logic [W:0]         a_ext_c;
  logic [BW-1:0]      b_ext_c;
  logic [R:0]         digit_c;
  logic [R:0]         mag_c;
  logic               neg_c;
  logic [PP_W-1:0]    a1_c;
  logic [PP_W-1:0]    mult_c;
  logic [PP_W-1:0]    pp_c;
  logic [ACC_W-1:0]   term_c;
  logic [ACC_W-1:0]   acc_next_c;

  assign accept_c = in_valid && in_ready;
  assign last_c   = (cnt == CNT_W'(NUM_TERMS - 1));
  assign a_ext_c  = {is_signed & multiplicand[W-1], multiplicand};
  assign b_ext_c  = {{PAD_W{is_signed & multiplier[W-1]}}, multiplier, 1'b0};

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept_c) state_next = (R == 3) ? PRECOMP : ITER;
      PRECOMP: state_next = ITER;
      ITER:    if (last_c) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Booth digit from the low R+1 window bits, then the selected multiple of A
  always_comb begin
    digit_c = {b_sr[R], b_sr[R:1]} + (R+1)'(b_sr[0]);
    neg_c   = digit_c[R];
    mag_c   = neg_c ? -digit_c : digit_c;
    a1_c    = {{3{a_reg[W]}}, a_reg};
    mult_c  = '0;
    case (mag_c)
      (R+1)'(1): mult_c = a1_c;
      (R+1)'(2): mult_c = a1_c << 1;
      (R+1)'(3): mult_c = {a3_reg[W+2], a3_reg};
      (R+1)'(4): mult_c = a1_c << 2;
      default:   mult_c = '0;
    endcase
    pp_c       = neg_c ? -mult_c : mult_c;
    term_c     = {{(ACC_W - PP_W){pp_c[PP_W-1]}}, pp_c} << (cnt * R);
    acc_next_c = acc + term_c;
  end

  // Operand, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      a3_reg  <= '0;
      b_sr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_reg  <= a_ext_c;
            b_sr   <= b_ext_c;
            a3_reg <= '0;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        PRECOMP: a3_reg <= {{2{a_reg[W]}}, a_reg} + {a_reg[W], a_reg, 1'b0};
        ITER: begin
          acc  <= acc_next_c;
          b_sr <= b_sr >> R;
          cnt  <= cnt + CNT_W'(1);
          if (last_c) product <= acc_next_c[PW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Handshake and status flags track the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and randomised checks of booth_seq_multiplier at W=6 and W=9,
// radix-8 and radix-4 instances driven in lockstep.
module tb_booth_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic        iv6, sg6, or6;
  logic [5:0]  a6, b6;
  logic        ir_r3, ov_r3, bz_r3, ir_r2, ov_r2, bz_r2;
  logic [11:0] p_r3, p_r2;

  logic        iv9, sg9, or9;
  logic [8:0]  a9, b9;
  logic        ir9_r3, ov9_r3, bz9_r3, ir9_r2, ov9_r2, bz9_r2;
  logic [17:0] p9_r3, p9_r2;

  booth_seq_multiplier #(.DATA_WIDTH(6), .RADIX_LOG2(3)) u_w6_r3 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir_r3), .multiplicand(a6),
    .multiplier(b6), .is_signed(sg6), .out_valid(ov_r3), .out_ready(or6),
    .product(p_r3), .busy(bz_r3));
  booth_seq_multiplier #(.DATA_WIDTH(6), .RADIX_LOG2(2)) u_w6_r2 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir_r2), .multiplicand(a6),
    .multiplier(b6), .is_signed(sg6), .out_valid(ov_r2), .out_ready(or6),
    .product(p_r2), .busy(bz_r2));
  booth_seq_multiplier #(.DATA_WIDTH(9), .RADIX_LOG2(3)) u_w9_r3 (
    .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(ir9_r3), .multiplicand(a9),
    .multiplier(b9), .is_signed(sg9), .out_valid(ov9_r3), .out_ready(or9),
    .product(p9_r3), .busy(bz9_r3));
  booth_seq_multiplier #(.DATA_WIDTH(9), .RADIX_LOG2(2)) u_w9_r2 (
    .clk(clk), .rst(rst), .in_valid(iv9), .in_ready(ir9_r2), .multiplicand(a9),
    .multiplier(b9), .is_signed(sg9), .out_valid(ov9_r2), .out_ready(or9),
    .product(p9_r2), .busy(bz9_r2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One W=6 operation with out_ready high; returns latency, product and out_valid one cycle later
  task automatic run6(input logic [5:0] a, input logic [5:0] b, input logic s,
                      output int lat3, output int lat2,
                      output logic [11:0] p3, output logic [11:0] p2,
                      output logic ov3_after, output logic ov2_after);
    a6 = a; b6 = b; sg6 = s; iv6 = 1'b1; or6 = 1'b1;
    tick;
    iv6 = 1'b0; a6 = ~a; b6 = ~b; sg6 = ~s;
    lat3 = -1; lat2 = -1; p3 = '0; p2 = '0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (ov_r3 && lat3 < 0) begin lat3 = k; p3 = p_r3; end
      if (ov_r2 && lat2 < 0) begin lat2 = k; p2 = p_r2; end
      if (lat3 >= 0 && lat2 >= 0) break;
    end
    tick;
    ov3_after = ov_r3;
    ov2_after = ov_r2;
  endtask

  task automatic test_reset;
    total++; if ({ir_r3, ov_r3, bz_r3} !== 3'b100) begin bad++; $display("FAIL reset_flags_w6r3 got=%b want=100", {ir_r3, ov_r3, bz_r3}); end
    total++; if (p_r3 !== 12'h000) begin bad++; $display("FAIL reset_product_w6r3 got=%h want=000", p_r3); end
    total++; if ({ir_r2, ov_r2, bz_r2} !== 3'b100) begin bad++; $display("FAIL reset_flags_w6r2 got=%b want=100", {ir_r2, ov_r2, bz_r2}); end
    total++; if (p_r2 !== 12'h000) begin bad++; $display("FAIL reset_product_w6r2 got=%h want=000", p_r2); end
    total++; if ({ir9_r3, ov9_r3, bz9_r3} !== 3'b100) begin bad++; $display("FAIL reset_flags_w9r3 got=%b want=100", {ir9_r3, ov9_r3, bz9_r3}); end
    total++; if (p9_r3 !== 18'h0) begin bad++; $display("FAIL reset_product_w9r3 got=%h want=0", p9_r3); end
    total++; if ({ir9_r2, ov9_r2, bz9_r2} !== 3'b100) begin bad++; $display("FAIL reset_flags_w9r2 got=%b want=100", {ir9_r2, ov9_r2, bz9_r2}); end
    total++; if (p9_r2 !== 18'h0) begin bad++; $display("FAIL reset_product_w9r2 got=%h want=0", p9_r2); end
  endtask

  task automatic test_basic;
    int l3, l2; logic [11:0] q3, q2; logic o3, o2;
    run6(6'b110101, 6'b011011, 1'b0, l3, l2, q3, q2, o3, o2);
    total++; if (q3 !== 12'h597) begin bad++; $display("FAIL basic_prod_r3 got=%h want=597", q3); end
    total++; if (q2 !== 12'h597) begin bad++; $display("FAIL basic_prod_r2 got=%h want=597", q2); end
    total++; if (l3 !== 4) begin bad++; $display("FAIL basic_lat_r3 got=%0d want=4", l3); end
    total++; if (l2 !== 4) begin bad++; $display("FAIL basic_lat_r2 got=%0d want=4", l2); end
    total++; if (o3 !== 1'b0) begin bad++; $display("FAIL basic_ovpulse_r3 got=%b want=0", o3); end
    total++; if (o2 !== 1'b0) begin bad++; $display("FAIL basic_ovpulse_r2 got=%b want=0", o2); end
    total++; if (ir_r3 !== 1'b1 || ir_r2 !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b%b want=11", ir_r3, ir_r2); end
  endtask

  task automatic test_signed;
    int l3, l2; logic [11:0] q3, q2; logic o3, o2;
    run6(6'b110101, 6'b011011, 1'b1, l3, l2, q3, q2, o3, o2);
    total++; if (q3 !== 12'hED7) begin bad++; $display("FAIL signed_prod_r3 got=%h want=ed7", q3); end
    total++; if (q2 !== 12'hED7) begin bad++; $display("FAIL signed_prod_r2 got=%h want=ed7", q2); end
    total++; if (l3 !== 4) begin bad++; $display("FAIL signed_lat_r3 got=%0d want=4", l3); end
    total++; if (l2 !== 4) begin bad++; $display("FAIL signed_lat_r2 got=%0d want=4", l2); end
  endtask

  task automatic test_bounds;
    logic [5:0]  va [3] = '{6'h3F, 6'h20, 6'h00};
    logic [5:0]  vb [3] = '{6'h3F, 6'h20, 6'h2A};
    logic        vs [3] = '{1'b0, 1'b1, 1'b1};
    logic [11:0] ve [3] = '{12'hF81, 12'h400, 12'h000};
    int l3, l2; logic [11:0] q3, q2; logic o3, o2;
    for (int i = 0; i < 3; i++) begin
      run6(va[i], vb[i], vs[i], l3, l2, q3, q2, o3, o2);
      total++; if (q3 !== ve[i]) begin bad++; $display("FAIL bound%0d_prod_r3 got=%h want=%h", i, q3, ve[i]); end
      total++; if (q2 !== ve[i]) begin bad++; $display("FAIL bound%0d_prod_r2 got=%h want=%h", i, q2, ve[i]); end
      total++; if (l3 !== 4) begin bad++; $display("FAIL bound%0d_lat_r3 got=%0d want=4", i, l3); end
      total++; if (l2 !== 4) begin bad++; $display("FAIL bound%0d_lat_r2 got=%0d want=4", i, l2); end
    end
  endtask

  task automatic test_back_pressure;
    int k; int l3, l2; logic [11:0] q3, q2; logic o3, o2;
    a6 = 6'd7; b6 = 6'd9; sg6 = 1'b0; iv6 = 1'b1; or6 = 1'b0;
    tick;
    iv6 = 1'b0;
    for (k = 1; k <= 20; k++) begin
      tick;
      if (ov_r3 && ov_r2) break;
    end
    total++; if (k !== 4) begin bad++; $display("FAIL bp_latency got=%0d want=4", k); end
    for (int c = 0; c < 7; c++) begin
      iv6 = 1'b1; a6 = 6'h11; b6 = 6'h22; sg6 = 1'b1;
      total++; if ({ov_r3, ov_r2} !== 2'b11) begin bad++; $display("FAIL bp_hold_valid c%0d got=%b want=11", c, {ov_r3, ov_r2}); end
      total++; if (p_r3 !== 12'h03F) begin bad++; $display("FAIL bp_hold_prod_r3 c%0d got=%h want=03f", c, p_r3); end
      total++; if (p_r2 !== 12'h03F) begin bad++; $display("FAIL bp_hold_prod_r2 c%0d got=%h want=03f", c, p_r2); end
      total++; if ({ir_r3, ir_r2} !== 2'b00) begin bad++; $display("FAIL bp_hold_ready c%0d got=%b want=00", c, {ir_r3, ir_r2}); end
      tick;
    end
    iv6 = 1'b0; or6 = 1'b1;
    tick;
    total++; if ({ov_r3, ov_r2} !== 2'b00) begin bad++; $display("FAIL bp_release_valid got=%b want=00", {ov_r3, ov_r2}); end
    total++; if ({ir_r3, ir_r2} !== 2'b11) begin bad++; $display("FAIL bp_release_ready got=%b want=11", {ir_r3, ir_r2}); end
    total++; if (p_r3 !== 12'h03F) begin bad++; $display("FAIL bp_release_keep got=%h want=03f", p_r3); end
    run6(6'd2, 6'd3, 1'b0, l3, l2, q3, q2, o3, o2);
    total++; if (q3 !== 12'h006 || q2 !== 12'h006) begin bad++; $display("FAIL bp_next_prod got=%h/%h want=006", q3, q2); end
    total++; if (l3 !== 4 || l2 !== 4) begin bad++; $display("FAIL bp_next_lat got=%0d/%0d want=4", l3, l2); end
  endtask

  task automatic test_reset_mid;
    int l3, l2; logic [11:0] q3, q2; logic o3, o2;
    a6 = 6'h15; b6 = 6'h2B; sg6 = 1'b1; iv6 = 1'b1; or6 = 1'b1;
    tick;
    iv6 = 1'b0;
    tick;
    tick;
    total++; if ({bz_r3, bz_r2, ir_r3, ir_r2} !== 4'b1100) begin bad++; $display("FAIL mid_busy got=%b want=1100", {bz_r3, bz_r2, ir_r3, ir_r2}); end
    #1 rst = 1'b1;
    #1;
    total++; if ({ov_r3, ov_r2} !== 2'b00) begin bad++; $display("FAIL mid_rst_valid got=%b want=00", {ov_r3, ov_r2}); end
    total++; if (p_r3 !== 12'h000 || p_r2 !== 12'h000) begin bad++; $display("FAIL mid_rst_prod got=%h/%h want=000", p_r3, p_r2); end
    total++; if ({ir_r3, ir_r2} !== 2'b11) begin bad++; $display("FAIL mid_rst_ready got=%b want=11", {ir_r3, ir_r2}); end
    total++; if ({bz_r3, bz_r2} !== 2'b00) begin bad++; $display("FAIL mid_rst_busy got=%b want=00", {bz_r3, bz_r2}); end
    tick;
    rst = 1'b0;
    tick;
    run6(6'd5, 6'd3, 1'b0, l3, l2, q3, q2, o3, o2);
    total++; if (q3 !== 12'h00F || q2 !== 12'h00F) begin bad++; $display("FAIL mid_after_prod got=%h/%h want=00f", q3, q2); end
    total++; if (l3 !== 4 || l2 !== 4) begin bad++; $display("FAIL mid_after_lat got=%0d/%0d want=4", l3, l2); end
  endtask

  task automatic test_random6(input int n);
    logic [5:0] a, b; logic s; longint sa, sb; logic [11:0] exp; int k;
    for (int i = 0; i < n; i++) begin
      a = 6'($urandom); b = 6'($urandom); s = 1'($urandom_range(0, 1));
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      exp = 12'(sa * sb);
      total++;
      if ({ir_r3, ir_r2} !== 2'b11) begin bad++; $display("FAIL rnd6_ready op%0d got=%b want=11", i, {ir_r3, ir_r2}); return; end
      a6 = a; b6 = b; sg6 = s; iv6 = 1'b1; or6 = 1'b0;
      tick;
      iv6 = 1'b0; a6 = 6'($urandom); b6 = 6'($urandom); sg6 = ~s;
      for (k = 1; k <= 20; k++) begin
        tick;
        if (ov_r3 && ov_r2) break;
      end
      repeat ($urandom_range(0, 3)) tick;
      total++; if (k !== 4) begin bad++; $display("FAIL rnd6_lat op%0d got=%0d want=4", i, k); end
      total++; if (p_r3 !== exp) begin bad++; $display("FAIL rnd6_r3 a=%h b=%h s=%b got=%h want=%h", a, b, s, p_r3, exp); end
      total++; if (p_r2 !== exp) begin bad++; $display("FAIL rnd6_r2 a=%h b=%h s=%b got=%h want=%h", a, b, s, p_r2, exp); end
      or6 = 1'b1;
      tick;
      or6 = 1'b0;
    end
  endtask

  task automatic test_random9(input int n);
    logic [8:0] a, b; logic s; longint sa, sb; logic [17:0] exp; int k;
    for (int i = 0; i < n; i++) begin
      a = 9'($urandom); b = 9'($urandom); s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 9'h1FF; b = 9'h1FF; s = 1'b0; end
      if (i == 1) begin a = 9'h100; b = 9'h100; s = 1'b1; end
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      exp = 18'(sa * sb);
      total++;
      if ({ir9_r3, ir9_r2} !== 2'b11) begin bad++; $display("FAIL rnd9_ready op%0d got=%b want=11", i, {ir9_r3, ir9_r2}); return; end
      a9 = a; b9 = b; sg9 = s; iv9 = 1'b1; or9 = 1'b0;
      tick;
      iv9 = 1'b0; a9 = 9'($urandom); b9 = 9'($urandom); sg9 = ~s;
      for (k = 1; k <= 20; k++) begin
        tick;
        if (ov9_r3 && ov9_r2) break;
      end
      repeat ($urandom_range(0, 3)) tick;
      total++; if (k !== 5) begin bad++; $display("FAIL rnd9_lat op%0d got=%0d want=5", i, k); end
      total++; if (p9_r3 !== exp) begin bad++; $display("FAIL rnd9_r3 a=%h b=%h s=%b got=%h want=%h", a, b, s, p9_r3, exp); end
      total++; if (p9_r2 !== exp) begin bad++; $display("FAIL rnd9_r2 a=%h b=%h s=%b got=%h want=%h", a, b, s, p9_r2, exp); end
      or9 = 1'b1;
      tick;
      or9 = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    iv6 = 1'b0; sg6 = 1'b0; or6 = 1'b0; a6 = '0; b6 = '0;
    iv9 = 1'b0; sg9 = 1'b0; or9 = 1'b0; a9 = '0; b9 = '0;
    tick;
    tick;
    test_reset();
    rst = 1'b0;
    tick;
    test_basic();
    test_signed();
    test_bounds();
    test_back_pressure();
    test_reset_mid();
    test_random6(2000);
    test_random9(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
